// File: rtl/formula_2_pkg.sv
// Shared constants for the formula_2 result buffer: default geometry and
// the bit positions inside the sticky error vector.
package formula_2_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;

    localparam int ERR_OVF   = 0;
    localparam int ERR_UNEXP = 1;

    localparam int ERR_W     = 2;

    typedef logic [ERR_W-1:0] err_t;

endpackage : formula_2_pkg

// File: rtl/flow_fifo.sv
// Power-of-two circular buffer with registered occupancy; a push into a full
// buffer is only taken when the head leaves in the same cycle.
module flow_fifo
    import formula_2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && !w_push;

    // Pointers wrap modulo DEPTH purely through their AW-bit width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale words are unreachable once the
    // pointers and count are cleared, and resetting a RAM array is costly.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule : flow_fifo

// File: rtl/formula_2_result_buf.sv
// Credit-managed result buffer beside formula_2_pipe: issues are only granted
// while every in-flight result is guaranteed a free FIFO slot on return.
module formula_2_result_buf
    import formula_2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     arg_rdy,
    input  logic                     arg_vld,
    input  logic                     res_vld,
    input  logic [WIDTH-1:0]         res,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] r_in_flight;
    logic [CW-1:0] w_in_flight_nxt;
    err_t          r_err;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit_sum;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic          w_issue;
    logic          w_ret;
    logic          w_unexp;
    logic          w_pop;

    flow_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (res_vld),
        .i_data  (res),
        .i_pop   (out_rdy),
        .o_data  (out_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // Credit check uses registered state only, so arg_rdy has no input path.
    assign w_credit_sum = {1'b0, r_in_flight} + {1'b0, w_count};
    assign arg_rdy      = (w_credit_sum < (CW+1)'(DEPTH));

    assign w_issue  = arg_vld && arg_rdy;
    assign w_ret    = res_vld && (r_in_flight != '0);
    assign w_unexp  = res_vld && (r_in_flight == '0);
    assign w_pop    = out_vld && out_rdy;

    assign out_vld  = !w_empty;
    assign count    = w_count;
    assign err      = r_err;

    // NOTE: always_comb assigns every output a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_in_flight_nxt = r_in_flight;
        unique case ({w_issue, w_ret})
            2'b10:   w_in_flight_nxt = r_in_flight + 1'b1;
            2'b01:   w_in_flight_nxt = r_in_flight - 1'b1;
            default: w_in_flight_nxt = r_in_flight;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_flight <= '0;
            r_err       <= '0;
        end else begin
            r_in_flight      <= w_in_flight_nxt;
            r_err[ERR_OVF]   <= r_err[ERR_OVF]   | (w_drop && !w_pop);
            r_err[ERR_UNEXP] <= r_err[ERR_UNEXP] | w_unexp;
        end
    end

endmodule : formula_2_result_buf

// File: tb/tb_formula_2_result_buf.sv
// Scoreboard bench: a latency-6 stand-in for formula_2_pipe feeds the buffer,
// expectations are queued at issue and a negedge monitor checks every pop.
module tb_formula_2_result_buf;
    import formula_2_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int L     = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             arg_vld = 1'b0;
    logic [WIDTH-1:0] arg_data = '0;
    logic             out_rdy = 1'b0;
    logic             f_vld = 1'b0;
    logic [WIDTH-1:0] f_data = '0;

    logic             arg_rdy;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic [1:0]       err;

    logic [L-1:0]     p_vld = '0;
    logic [WIDTH-1:0] p_dat [L];
    logic             issue_s = 1'b0;
    logic [WIDTH-1:0] issue_d = '0;

    logic [WIDTH-1:0] sb [$];
    int               tests = 0;
    int               fails = 0;
    int               n_issue = 0;
    int               n_rx = 0;
    int               rdy_low = 0;
    logic             lat_chk = 1'b0;
    logic             res_prev = 1'b0;

    always #5 clk = ~clk;

    formula_2_result_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arg_rdy  (arg_rdy),
        .arg_vld  (arg_vld),
        .res_vld  (res_vld),
        .res      (res),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .count    (count),
        .err      (err)
    );

    function automatic logic [WIDTH-1:0] f2(input logic [WIDTH-1:0] x);
        return x * 32'd3 + 32'h100;
    endfunction

    assign res_vld = p_vld[L-1] | f_vld;
    assign res     = p_vld[L-1] ? p_dat[L-1] : f_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        arg_vld = 1'b0;
        f_vld   = 1'b0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete();
        #1 rst = 1'b1;
    endtask

    // Pipe stand-in: issue sampled mid-cycle, result emerges L edges later.
    always @(negedge clk) begin
        issue_s = arg_vld && arg_rdy && rst;
        issue_d = arg_data;
        if (issue_s) begin
            n_issue++;
            sb.push_back(f2(arg_data));
        end
    end

    always @(posedge clk) begin
        p_vld    <= {p_vld[L-2:0], issue_s};
        p_dat[0] <= f2(issue_d);
        for (int i = 1; i < L; i++) begin
            p_dat[i] <= p_dat[i-1];
        end
    end

    // Monitor: compares each accepted head against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (lat_chk && res_prev) begin
                check("out_vld_after_res", 32'(out_vld), 32'd1);
            end
            res_prev = res_vld;
            if (out_vld && out_data == 32'hDEAD) begin
                tests++;
                fails++;
                $display("FAIL dropped_word_seen: got 0x%0h expected never", out_data);
            end
            if (out_vld && out_rdy) begin
                n_rx++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got 0x%0h expected no output", out_data);
                end else begin
                    check("sb_data", out_data, sb.pop_front());
                end
            end
        end else begin
            res_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, asserted asynchronously before any clock edge.
        #1 rst = 1'b0;
        #1;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_count",   32'(count),   32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_arg_rdy", 32'(arg_rdy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        check("post_rst_arg_rdy", 32'(arg_rdy), 32'd1);

        // Result with nothing in flight: flagged, stored, in_flight stays 0.
        f_data = 32'h1111;
        f_vld  = 1'b1;
        sb.push_back(32'h1111);
        cyc();
        f_vld = 1'b0;
        check("unexp_err",       32'(err),             32'b10);
        check("unexp_count",     32'(count),           32'd1);
        check("unexp_out_vld",   32'(out_vld),         32'd1);
        check("unexp_in_flight", 32'(dut.r_in_flight), 32'd0);
        out_rdy = 1'b1;
        repeat (2) cyc();
        out_rdy = 1'b0;
        check("unexp_drained", 32'(sb.size()), 32'd0);
        do_reset();

        // Credit exhaustion with the consumer stalled.
        n_issue = 0;
        arg_vld = 1'b1;
        for (int i = 0; i < 24; i++) begin
            arg_data = 32'h10 + 32'(i);
            cyc();
        end
        arg_vld = 1'b0;
        check("exh_arg_rdy_low", 32'(arg_rdy), 32'd0);
        repeat (L + 2) cyc();
        check("exh_issues",  32'(n_issue), 32'd16);
        check("exh_count",   32'(count),   32'd16);
        check("exh_err",     32'(err),     32'd0);
        check("exh_arg_rdy", 32'(arg_rdy), 32'd0);

        // Full with push and pop together; the forced beat holds no credit,
        // so only the unexpected-result flag may rise.
        out_rdy = 1'b1;
        f_data  = 32'hBEEF;
        f_vld   = 1'b1;
        sb.push_back(32'hBEEF);
        cyc();
        f_vld   = 1'b0;
        out_rdy = 1'b0;
        check("full_pp_count", 32'(count), 32'd16);
        check("full_pp_err",   32'(err),   32'b10);

        // Forced overflow: word dropped, head and count untouched.
        f_data = 32'hDEAD;
        f_vld  = 1'b1;
        cyc();
        f_vld = 1'b0;
        check("ovf_err",   32'(err),      32'b11);
        check("ovf_count", 32'(count),    32'd16);
        check("ovf_head",  out_data,      32'h133);
        out_rdy = 1'b1;
        repeat (20) cyc();
        out_rdy = 1'b0;
        check("ovf_drain_sb",    32'(sb.size()), 32'd0);
        check("ovf_drain_count", 32'(count),     32'd0);
        do_reset();

        // Streaming: 100 back-to-back issues with the consumer always ready.
        out_rdy = 1'b1;
        n_rx    = 0;
        rdy_low = 0;
        lat_chk = 1'b1;
        arg_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            arg_data = 32'h1000 + 32'(i);
            if (!arg_rdy) rdy_low++;
            cyc();
        end
        arg_vld = 1'b0;
        repeat (L + 4) cyc();
        lat_chk = 1'b0;
        check("stream_rdy_low", 32'(rdy_low),   32'd0);
        check("stream_rx",      32'(n_rx),      32'd100);
        check("stream_sb",      32'(sb.size()), 32'd0);
        check("stream_err",     32'(err),       32'd0);
        do_reset();

        // Reset mid-stream: 5 buffered, 3 in flight, short async pulse.
        arg_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            arg_data = 32'h200 + 32'(i);
            cyc();
        end
        arg_vld = 1'b0;
        repeat (L + 2) cyc();
        check("mid_count5", 32'(count), 32'd5);
        arg_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            arg_data = 32'h300 + 32'(i);
            cyc();
        end
        arg_vld = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("mid_rst_out_vld", 32'(out_vld), 32'd0);
        check("mid_rst_count",   32'(count),   32'd0);
        check("mid_rst_arg_rdy", 32'(arg_rdy), 32'd1);
        check("mid_rst_err",     32'(err),     32'd0);
        rst = 1'b1;
        repeat (L + 2) cyc();
        check("late_res_err",       32'(err),             32'b10);
        check("late_res_count",     32'(count),           32'd3);
        check("late_res_in_flight", 32'(dut.r_in_flight), 32'd0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_formula_2_result_buf
